// File: rtl/can_frame_pkg.sv
// can_frame_pkg: CAN frame field codes and fixed field lengths shared by frame-level blocks.
package can_frame_pkg;

    typedef enum logic [3:0] {
        F_IDLE    = 4'd0,
        F_SOF     = 4'd1,
        F_ID_A    = 4'd2,
        F_SRR_RTR = 4'd3,
        F_IDE     = 4'd4,
        F_ID_B    = 4'd5,
        F_RTR     = 4'd6,
        F_R1      = 4'd7,
        F_R0      = 4'd8,
        F_DLC     = 4'd9,
        F_DATA    = 4'd10,
        F_CRC     = 4'd11,
        F_CRC_DEL = 4'd12,
        F_ACK     = 4'd13,
        F_ACK_DEL = 4'd14,
        F_EOF     = 4'd15
    } field_e;

    localparam int LEN_W = 7;

    localparam logic [LEN_W-1:0] LEN_ID_A    = 7'd11;
    localparam logic [LEN_W-1:0] LEN_SRR_RTR = 7'd1;
    localparam logic [LEN_W-1:0] LEN_IDE     = 7'd1;
    localparam logic [LEN_W-1:0] LEN_ID_B    = 7'd18;
    localparam logic [LEN_W-1:0] LEN_RTR     = 7'd1;
    localparam logic [LEN_W-1:0] LEN_R1      = 7'd1;
    localparam logic [LEN_W-1:0] LEN_R0      = 7'd1;
    localparam logic [LEN_W-1:0] LEN_DLC     = 7'd4;
    localparam logic [LEN_W-1:0] LEN_CRC     = 7'd15;
    localparam logic [LEN_W-1:0] LEN_CRC_DEL = 7'd1;
    localparam logic [LEN_W-1:0] LEN_ACK     = 7'd1;
    localparam logic [LEN_W-1:0] LEN_ACK_DEL = 7'd1;
    localparam logic [LEN_W-1:0] LEN_EOF     = 7'd7;

endpackage

// File: rtl/frame_field_tracker.sv
// frame_field_tracker: follows a CAN frame bit by bit, reporting current field, position,
// non-stuff bit count and the latched IDE/RTR/DLC attributes.
module frame_field_tracker
    import can_frame_pkg::*;
#(
    parameter int CNT_W     = 10,
    parameter int MAX_BYTES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sp,
    input  logic             is_stuff,
    input  logic             rx_bit,
    input  logic             abort,
    output logic [CNT_W-1:0] size,
    output logic [3:0]       field,
    output logic [5:0]       bit_idx,
    output logic             ide,
    output logic             rtr,
    output logic [3:0]       dlc,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [3:0] MAXB = (MAX_BYTES > 15) ? 4'd15 : 4'(MAX_BYTES);

    field_e           field_q, field_d, field_nxt;
    logic [CNT_W-1:0] size_q, size_d;
    logic [5:0]       bit_idx_q, bit_idx_d;
    logic             ide_q, ide_d, rtr_q, rtr_d, frame_done_q, frame_done_d;
    logic [3:0]       dlc_q, dlc_d, dlc_shift, n_cur, n_nxt;
    logic [LEN_W-1:0] field_len, idx_inc;
    logic             vbit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            field_q      <= F_IDLE;
            size_q       <= '0;
            bit_idx_q    <= '0;
            ide_q        <= 1'b0;
            rtr_q        <= 1'b0;
            dlc_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            field_q      <= field_d;
            size_q       <= size_d;
            bit_idx_q    <= bit_idx_d;
            ide_q        <= ide_d;
            rtr_q        <= rtr_d;
            dlc_q        <= dlc_d;
            frame_done_q <= frame_done_d;
        end
    end

    // n_nxt sees the DLC value including the bit arriving now, so DATA can be skipped on the DLC edge
    always_comb begin
        vbit      = sp & ~is_stuff;
        dlc_shift = {dlc_q[2:0], rx_bit};
        n_cur     = rtr_q ? 4'd0 : ((dlc_q > MAXB) ? MAXB : dlc_q);
        n_nxt     = rtr_q ? 4'd0 : ((dlc_shift > MAXB) ? MAXB : dlc_shift);
        idx_inc   = {1'b0, bit_idx_q} + 7'd1;
        case (field_q)
            F_ID_A:    field_len = LEN_ID_A;
            F_SRR_RTR: field_len = LEN_SRR_RTR;
            F_IDE:     field_len = LEN_IDE;
            F_ID_B:    field_len = LEN_ID_B;
            F_RTR:     field_len = LEN_RTR;
            F_R1:      field_len = LEN_R1;
            F_R0:      field_len = LEN_R0;
            F_DLC:     field_len = LEN_DLC;
            F_DATA:    field_len = {n_cur, 3'b000};
            F_CRC:     field_len = LEN_CRC;
            F_CRC_DEL: field_len = LEN_CRC_DEL;
            F_ACK:     field_len = LEN_ACK;
            F_ACK_DEL: field_len = LEN_ACK_DEL;
            F_EOF:     field_len = LEN_EOF;
            default:   field_len = 7'd1;
        endcase
        case (field_q)
            F_ID_A:    field_nxt = F_SRR_RTR;
            F_SRR_RTR: field_nxt = F_IDE;
            F_IDE:     field_nxt = rx_bit ? F_ID_B : F_R0;
            F_ID_B:    field_nxt = F_RTR;
            F_RTR:     field_nxt = F_R1;
            F_R1:      field_nxt = F_R0;
            F_R0:      field_nxt = F_DLC;
            F_DLC:     field_nxt = (n_nxt == 4'd0) ? F_CRC : F_DATA;
            F_DATA:    field_nxt = F_CRC;
            F_CRC:     field_nxt = F_CRC_DEL;
            F_CRC_DEL: field_nxt = F_ACK;
            F_ACK:     field_nxt = F_ACK_DEL;
            F_ACK_DEL: field_nxt = F_EOF;
            default:   field_nxt = F_IDLE;
        endcase
    end

    always_comb begin
        field_d      = field_q;
        size_d       = size_q;
        bit_idx_d    = bit_idx_q;
        ide_d        = ide_q;
        rtr_d        = rtr_q;
        dlc_d        = dlc_q;
        frame_done_d = 1'b0;
        if (abort) begin
            field_d   = F_IDLE;
            bit_idx_d = '0;
        end else if (vbit && field_q == F_IDLE) begin
            if (!rx_bit) begin
                field_d   = F_ID_A;
                bit_idx_d = '0;
                size_d    = CNT_W'(1);
            end
        end else if (vbit) begin
            size_d = (&size_q) ? size_q : size_q + 1'b1;
            // extended frames overwrite the SRR-sourced rtr when the real RTR bit arrives
            if (field_q == F_SRR_RTR || field_q == F_RTR) rtr_d = rx_bit;
            if (field_q == F_IDE) ide_d = rx_bit;
            if (field_q == F_DLC) dlc_d = dlc_shift;
            if (idx_inc == field_len) begin
                field_d      = field_nxt;
                bit_idx_d    = '0;
                frame_done_d = (field_q == F_EOF);
            end else begin
                bit_idx_d = idx_inc[5:0];
            end
        end
    end

    assign size       = size_q;
    assign field      = field_q;
    assign bit_idx    = bit_idx_q;
    assign ide        = ide_q;
    assign rtr        = rtr_q;
    assign dlc        = dlc_q;
    assign busy       = (field_q != F_IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_field_tracker.sv
// tb_frame_field_tracker: random and directed CAN frames against a flattened-frame reference model.
module tb_frame_field_tracker;
    import can_frame_pkg::*;

    logic clk = 0, reset = 1, sp = 0, is_stuff = 0, rx_bit = 1, abort = 0;
    logic chk = 0, chk_p = 0;
    logic [9:0] size;
    logic [3:0] size4, field, field4, dlc, dlc4;
    logic [5:0] bit_idx, bit_idx4;
    logic ide, rtr, busy, frame_done, ide4, rtr4, busy4, fd4;

    frame_field_tracker dut (
        .clk(clk), .reset(reset), .sp(sp), .is_stuff(is_stuff), .rx_bit(rx_bit), .abort(abort),
        .size(size), .field(field), .bit_idx(bit_idx), .ide(ide), .rtr(rtr), .dlc(dlc),
        .busy(busy), .frame_done(frame_done)
    );

    frame_field_tracker #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .sp(sp), .is_stuff(is_stuff), .rx_bit(rx_bit), .abort(abort),
        .size(size4), .field(field4), .bit_idx(bit_idx4), .ide(ide4), .rtr(rtr4), .dlc(dlc4),
        .busy(busy4), .frame_done(fd4)
    );

    always #5 clk = ~clk;

    typedef struct {logic [3:0] f; int idx; int size;} exp_t;
    typedef struct {int size; logic ide; logic rtr; logic [3:0] dlc;} done_t;
    exp_t  eq[$];
    done_t dq[$];
    int vectors = 0, miscompares = 0;

    logic [3:0] sf[$];
    int         si[$];
    logic       sv[$];
    logic [3:0] cur_f = 4'd0;
    int         cur_i = 0, cur_s = 0;

    function automatic void cmp(string nm, int act, int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endfunction

    function automatic int sat15(int v);
        return (v > 15) ? 15 : v;
    endfunction

    always @(posedge clk) chk_p <= chk;

    always @(negedge clk) begin
        exp_t  e;
        done_t d;
        if (chk_p) begin
            if (eq.size() == 0) cmp("bit_queue_empty", 1, 0);
            else begin
                e = eq.pop_front();
                cmp("field", int'(field), int'(e.f));
                cmp("bit_idx", int'(bit_idx), e.idx);
                cmp("size", int'(size), e.size);
                cmp("busy", int'(busy), int'(e.f != 4'd0));
                cmp("size_w4", int'(size4), sat15(e.size));
            end
        end
        if (frame_done) begin
            if (dq.size() == 0) cmp("unexpected_frame_done", 1, 0);
            else begin
                d = dq.pop_front();
                cmp("done_size", int'(size), d.size);
                cmp("done_ide", int'(ide), int'(d.ide));
                cmp("done_rtr", int'(rtr), int'(d.rtr));
                cmp("done_dlc", int'(dlc), int'(d.dlc));
                cmp("done_size_w4", int'(size4), sat15(d.size));
                cmp("done_w4_pulse", int'(fd4), 1);
            end
        end
    end

    task automatic cyc(input logic s, input logic st, input logic rx, input logic ab, input logic c);
        @(posedge clk);
        #1;
        sp = s; is_stuff = st; rx_bit = rx; abort = ab; chk = c;
    endtask

    task automatic add(input logic [3:0] f, input int len, input logic [63:0] v);
        for (int i = 0; i < len; i++) begin
            sf.push_back(f); si.push_back(i); sv.push_back(v[len-1-i]);
        end
    endtask

    task automatic check_reset_state(input string tag);
        cmp({tag, "_size"}, int'(size), 0);
        cmp({tag, "_field"}, int'(field), 0);
        cmp({tag, "_bit_idx"}, int'(bit_idx), 0);
        cmp({tag, "_attr"}, int'({ide, rtr, dlc}), 0);
        cmp({tag, "_busy_done"}, int'({busy, frame_done}), 0);
        cmp({tag, "_w4"}, int'({size4, field4, busy4, fd4}), 0);
    endtask

    // cut_kind: 0 none, 1 abort with sp, 2 async reset; cut point is cut_off bits into cut_field
    task automatic send_frame(input logic fide, input logic frtr, input logic [3:0] fdlc,
                              input logic [28:0] id, input int nstuff,
                              input int cut_kind, input logic [3:0] cut_field, input int cut_off);
        int n, len, step, st_left, cut_at;
        logic [3:0] nf;
        int ni;
        sf.delete(); si.delete(); sv.delete();
        add(F_SOF, 1, 64'd0);
        if (!fide) begin
            add(F_ID_A, 11, {53'd0, id[10:0]});
            add(F_SRR_RTR, 1, {63'd0, frtr});
            add(F_IDE, 1, 64'd0);
            add(F_R0, 1, 64'($urandom_range(0, 1)));
        end else begin
            add(F_ID_A, 11, {53'd0, id[28:18]});
            add(F_SRR_RTR, 1, 64'd1);
            add(F_IDE, 1, 64'd1);
            add(F_ID_B, 18, {46'd0, id[17:0]});
            add(F_RTR, 1, {63'd0, frtr});
            add(F_R1, 1, 64'($urandom_range(0, 1)));
            add(F_R0, 1, 64'($urandom_range(0, 1)));
        end
        add(F_DLC, 4, {60'd0, fdlc});
        n = frtr ? 0 : ((fdlc > 8) ? 8 : int'(fdlc));
        if (n > 0) add(F_DATA, 8 * n, {$urandom, $urandom});
        add(F_CRC, 15, 64'($urandom));
        add(F_CRC_DEL, 1, 64'd1);
        add(F_ACK, 1, 64'd0);
        add(F_ACK_DEL, 1, 64'd1);
        add(F_EOF, 7, 64'h7f);
        len = sf.size();
        cut_at = -1;
        for (int i = 0; i < len; i++)
            if (cut_at < 0 && sf[i] == cut_field && cut_kind != 0) cut_at = i + cut_off;
        step = len / (nstuff + 1);
        st_left = nstuff;
        for (int k = 0; k < len; k++) begin
            repeat ($urandom_range(0, 2)) cyc(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
            if (st_left > 0 && k > 0 && k % step == 0) begin
                st_left--;
                cyc(1'b1, 1'b1, 1'($urandom), 1'b0, 1'b1);
                eq.push_back('{cur_f, cur_i, cur_s});
            end
            if (cut_kind == 1 && k == cut_at) begin
                cyc(1'b1, 1'b0, sv[k], 1'b1, 1'b1);
                cur_f = 4'd0; cur_i = 0;
                eq.push_back('{cur_f, cur_i, cur_s});
                break;
            end
            if (cut_kind == 2 && k == cut_at) begin
                @(negedge clk);
                #1;
                sp = 0; chk = 0; abort = 0; reset = 1;
                #1;
                check_reset_state("reset_mid_frame");
                @(negedge clk);
                reset = 0;
                cur_f = 4'd0; cur_i = 0; cur_s = 0;
                break;
            end
            cyc(1'b1, 1'b0, sv[k], 1'b0, 1'b1);
            nf = (k + 1 < len) ? sf[k+1] : 4'd0;
            ni = (k + 1 < len) ? si[k+1] : 0;
            cur_f = nf; cur_i = ni; cur_s = k + 1;
            eq.push_back('{cur_f, cur_i, cur_s});
            if (k == len - 1) dq.push_back('{len, fide, frtr, fdlc});
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // recessive bus idle: must not start a frame and must keep size
        repeat ($urandom_range(1, 3)) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            eq.push_back('{cur_f, cur_i, cur_s});
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check_reset_state("reset");
        @(negedge clk);
        reset = 0;
        send_frame(1'b0, 1'b0, 4'd2, 29'h123, 0, 0, 4'd0, 0);
        send_frame(1'b1, 1'b0, 4'd8, 29'h1abcdef, 0, 0, 4'd0, 0);
        send_frame(1'b0, 1'b1, 4'd4, 29'h055, 0, 0, 4'd0, 0);
        send_frame(1'b0, 1'b0, 4'd15, 29'h7ff, 0, 0, 4'd0, 0);
        send_frame(1'b0, 1'b0, 4'd2, 29'h123, 5, 0, 4'd0, 0);
        send_frame(1'b0, 1'b0, 4'd3, 29'h321, 0, 1, F_DATA, 5);
        send_frame(1'b0, 1'b0, 4'd1, 29'h0, 0, 0, 4'd0, 0);
        send_frame(1'b1, 1'b0, 4'd6, 29'h0abc, 2, 2, F_CRC, 7);
        send_frame(1'b1, 1'b1, 4'd9, 29'h1fff_ffff, 0, 0, 4'd0, 0);
        for (int r = 0; r < 24; r++)
            send_frame(1'($urandom), 1'($urandom_range(0, 3) == 0), 4'($urandom), 29'($urandom),
                       $urandom_range(0, 6), ($urandom_range(0, 5) == 0) ? 1 : 0,
                       F_CRC, $urandom_range(0, 14));
        repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cmp("bit_queue_drained", eq.size(), 0);
        cmp("done_queue_drained", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_field_tracker.md
FRAME_FIELD_TRACKER -- requirements
Module: frame_field_tracker

Interface
REQ-001 SHALL have parameter CNT_W, default 10, width of the frame bit counter.
REQ-002 SHALL have parameter MAX_BYTES, default 8, cap on data bytes derived from DLC.
REQ-003 SHALL have port clk, input, 1, system clock; all state changes occur on the rising edge.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port sp, input, 1, sample-point strobe, one clk wide per CAN bit.
REQ-006 SHALL have port is_stuff, input, 1, qualifies sp; high means the current bit is a stuff bit.
REQ-007 SHALL have port rx_bit, input, 1, sampled bus value at sp (0 = dominant).
REQ-008 SHALL have port abort, input, 1, synchronous frame abort (error or overload detected).
REQ-009 SHALL have port size, output, CNT_W, count of non-stuff bits since SOF, SOF included.
REQ-010 SHALL have port field, output, 4, current field code from the package.
REQ-011 SHALL have port bit_idx, output, 6, zero-based index of the next bit within the current field.
REQ-012 SHALL have ports ide, rtr, and dlc[3:0], outputs, latched frame attributes.
REQ-013 SHALL have ports busy and frame_done, outputs, 1 each; frame_done is a one-clk pulse.

Function
REQ-014 SHALL act only on clk edges where sp=1 and is_stuff=0 (a "valid bit"); any other edge holds all state.
REQ-015 SHALL accept SOF in IDLE on a valid bit with rx_bit=0: size:=1, field:=ID_A, busy:=1.
REQ-016 SHALL ignore recessive valid bits in IDLE; size holds its previous frame value.
REQ-017 SHALL increment size by 1 per valid bit in non-IDLE states; size saturates at 2^CNT_W-1 with no wrap.
REQ-018 SHALL use the field sequence SOF, ID_A(11), SRR_RTR(1), IDE(1), then either standard R0(1) or extended ID_B(18), RTR(1), R1(1), R0(1), then DLC(4), DATA(8*n), CRC(15), CRC_DEL(1), ACK(1), ACK_DEL(1), EOF(7).
REQ-019 SHALL latch the IDE bit into ide; standard frames latch rtr from SRR_RTR, extended frames latch rtr from the RTR field.
REQ-020 SHALL latch dlc MSB first; n = 0 if rtr=1, else min(dlc, MAX_BYTES); DATA is skipped when n=0.
REQ-021 SHALL reset bit_idx to 0 at each field transition and increment it per valid bit within the field.
REQ-022 SHALL, on the 7th EOF valid bit, pulse frame_done for one clk, enter IDLE, clear busy, and hold size, ide, rtr and dlc.
REQ-023 SHALL, on abort=1, enter IDLE next edge with busy:=0, frame_done:=0, and size held; abort wins over a simultaneous valid bit.
REQ-024 SHALL NOT check field content (CRC, delimiters, ACK); that belongs to other blocks.

Reset
REQ-025 SHALL on reset force: state IDLE, size 0, field IDLE, bit_idx 0, ide 0, rtr 0, dlc 0, busy 0, frame_done 0.
REQ-026 SHALL, when reset is asserted mid-frame, discard the frame immediately with no frame_done pulse.

Structure
REQ-027 SHALL take field codes (IDLE=0 … EOF) and fixed field lengths as constants from shared package can_frame_pkg.
REQ-028 SHALL be a single module with no sub-module; field length selection is an inline lookup on field, ide, and n.

Verification
REQ-029 SHALL cover: standard data frame, ID 0x123, DLC 2, no stuff bits -> frame_done with size=60, ide=0, rtr=0, dlc=2.
REQ-030 SHALL cover: extended data frame, DLC 8 -> size=128, ide=1 at frame_done.
REQ-031 SHALL cover: standard remote frame, DLC 4 -> DATA skipped, size=44, rtr=1; and standard DLC 15 -> size=108.
REQ-032 SHALL cover: the REQ-029 frame with 5 is_stuff=1 sp pulses interleaved -> size still 60, field sequence unchanged.
REQ-033 SHALL cover: abort together with sp inside DATA -> IDLE next clk, no frame_done, size held; the next SOF gives size=1.
REQ-034 SHALL cover: reset asserted during CRC -> all outputs match REQ-025 without waiting for a clk edge; CNT_W=4 with a long frame -> size saturates at 15.
